// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment (PLL wrapper + software).
// The master side is the sequencer itself; the slave side is the PLL/system that it controls.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       soft_reset;
  logic       fault_clear;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked, soft_reset, fault_clear,
    output pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_cnt
  );

  modport slave (
    output pll_locked, soft_reset, fault_clear,
    input  pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and bounded retries,
// debounces lock, then releases the system reset; re-sequences on lock loss or soft request.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                  : LOCK_STABLE_CYCLES;
  localparam int MAXC   = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, locked_s_q;
  logic          pll_rst_q, sys_rst_n_q, ready_q, fault_q;

  // pll_locked comes from the PLL's own lock detector, so it is asynchronous here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  // cnt_q is shared: pulse width in RESET_PLL, timeout in WAIT_LOCK, stable run in STABILIZE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_RESET_PLL: begin
        if (bus.soft_reset) begin
          cnt_d   = '0;
          retry_d = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (bus.soft_reset) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end else if (locked_s_q) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = '0;
          state_d = ((retry_q + 4'd1) == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STABILIZE: begin
        if (bus.soft_reset) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end else if (!locked_s_q) begin
          // A glitch is not a failed attempt: rearm the timeout, keep the retry count.
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (bus.soft_reset) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (bus.fault_clear) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_reset_n   = sys_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.retry_count   = retry_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule
